// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if
// Bundles the dispatch, CDB, operand-query, squash and retire signals of the
// reorder buffer.
//   master : dispatch/CDB/query/squash producer; reads dispatch_ready,
//            dispatch_tag, query results, retire stream, count and empty
//   slave  : the reorder buffer itself
// clock and reset are not part of the bundle.
interface reorder_buffer_if #(
    parameter int ROB_LEN = 8,
    parameter int TAG_W   = $clog2(ROB_LEN + 1)
);
    // Dispatch
    logic             dispatch_valid;
    logic [4:0]       dispatch_dest_reg;
    logic             dispatch_ready;
    logic [TAG_W-1:0] dispatch_tag;
    // Common data bus
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    // Operand lookups from the reservation station
    logic [TAG_W-1:0] rs1_query_tag;
    logic [TAG_W-1:0] rs2_query_tag;
    logic             rs1_query_ready;
    logic             rs2_query_ready;
    logic [31:0]      rs1_query_value;
    logic [31:0]      rs2_query_value;
    // Flush and retirement
    logic             squash;
    logic             retire_valid;
    logic [TAG_W-1:0] retire_tag;
    logic [4:0]       retire_dest_reg;
    logic [31:0]      retire_value;
    // Occupancy
    logic [TAG_W-1:0] count;
    logic             empty;

    modport master (
        output dispatch_valid, dispatch_dest_reg, cdb_valid, cdb_tag, cdb_value,
               rs1_query_tag, rs2_query_tag, squash,
        input  dispatch_ready, dispatch_tag, rs1_query_ready, rs2_query_ready,
               rs1_query_value, rs2_query_value, retire_valid, retire_tag,
               retire_dest_reg, retire_value, count, empty
    );

    modport slave (
        input  dispatch_valid, dispatch_dest_reg, cdb_valid, cdb_tag, cdb_value,
               rs1_query_tag, rs2_query_tag, squash,
        output dispatch_ready, dispatch_tag, rs1_query_ready, rs2_query_ready,
               rs1_query_value, rs2_query_value, retire_valid, retire_tag,
               retire_dest_reg, retire_value, count, empty
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer
// Circular reorder buffer: allocates one tag per dispatched instruction,
// captures results from the CDB, answers operand lookups and retires in
// program order. Tag 0 means "value is in the register file"; an entry at
// index i carries tag i+1.
// Ports:
//   clock : rising-edge system clock
//   reset : asynchronous active-high, clears all state
//   rob   : reorder_buffer_if.slave bundle (dispatch, CDB, queries, squash,
//           retire stream, count/empty)
module reorder_buffer #(
    parameter int ROB_LEN = 8,
    parameter int TAG_W   = $clog2(ROB_LEN + 1)
) (
    input  logic             clock,
    input  logic             reset,
    reorder_buffer_if.slave  rob
);
    localparam int IDX_W = $clog2(ROB_LEN);

    logic [ROB_LEN-1:0] valid_r;
    logic [ROB_LEN-1:0] complete_r;
    logic [4:0]         dest_reg_r [ROB_LEN];
    logic [31:0]        value_r    [ROB_LEN];
    logic [IDX_W-1:0]   head_r;
    logic [IDX_W-1:0]   tail_r;
    logic [TAG_W-1:0]   count_r;

    logic               dispatch_fire_s;
    logic               retire_fire_s;
    logic               cdb_hit_s;
    logic [IDX_W-1:0]   cdb_idx_s;
    logic               rs1_ready_s;
    logic               rs2_ready_s;
    logic [31:0]        rs1_value_s;
    logic [31:0]        rs2_value_s;

    // Tag -> entry index; tags above ROB_LEN alias but are rejected by tag_live.
    function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] tag);
        return IDX_W'(tag - TAG_W'(1));
    endfunction

    // A tag names a live entry only if it is in 1..ROB_LEN and that entry is valid.
    function automatic logic tag_live(input logic [TAG_W-1:0] tag);
        logic live;
        if ((tag != TAG_W'(0)) && (tag <= TAG_W'(ROB_LEN))) begin
            live = valid_r[tag_idx(tag)];
        end else begin
            live = 1'b0;
        end
        return live;
    endfunction

    // Handshake qualification; squash suppresses every state-changing event.
    always_comb begin
        dispatch_fire_s = rob.dispatch_valid && (count_r < TAG_W'(ROB_LEN)) && !rob.squash;
        retire_fire_s   = valid_r[head_r] && complete_r[head_r] && !rob.squash;
        cdb_idx_s       = tag_idx(rob.cdb_tag);
        cdb_hit_s       = rob.cdb_valid && tag_live(rob.cdb_tag);
    end

    // rs1 lookup: invalid/zero tag gives 0, same-cycle CDB forward wins over stored state.
    always_comb begin
        rs1_ready_s = 1'b0;
        rs1_value_s = 32'd0;
        if (tag_live(rob.rs1_query_tag)) begin
            if (rob.cdb_valid && (rob.cdb_tag == rob.rs1_query_tag)) begin
                rs1_ready_s = 1'b1;
                rs1_value_s = rob.cdb_value;
            end else begin
                rs1_ready_s = complete_r[tag_idx(rob.rs1_query_tag)];
                rs1_value_s = value_r[tag_idx(rob.rs1_query_tag)];
            end
        end else begin
            rs1_ready_s = 1'b0;
            rs1_value_s = 32'd0;
        end
    end

    // rs2 lookup: same rules as rs1.
    always_comb begin
        rs2_ready_s = 1'b0;
        rs2_value_s = 32'd0;
        if (tag_live(rob.rs2_query_tag)) begin
            if (rob.cdb_valid && (rob.cdb_tag == rob.rs2_query_tag)) begin
                rs2_ready_s = 1'b1;
                rs2_value_s = rob.cdb_value;
            end else begin
                rs2_ready_s = complete_r[tag_idx(rob.rs2_query_tag)];
                rs2_value_s = value_r[tag_idx(rob.rs2_query_tag)];
            end
        end else begin
            rs2_ready_s = 1'b0;
            rs2_value_s = 32'd0;
        end
    end

    // Entry array, pointers and occupancy counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r    <= '0;
            complete_r <= '0;
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            for (int i = 0; i < ROB_LEN; i++) begin
                dest_reg_r[i] <= 5'd0;
                value_r[i]    <= 32'd0;
            end
        end else if (rob.squash) begin
            valid_r    <= '0;
            complete_r <= '0;
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
        end else begin
            // Dispatch slot is never the CDB target (invalid) nor the head being
            // retired (that would need count == ROB_LEN, which blocks dispatch).
            if (dispatch_fire_s) begin
                valid_r[tail_r]    <= 1'b1;
                complete_r[tail_r] <= 1'b0;
                dest_reg_r[tail_r] <= rob.dispatch_dest_reg;
                value_r[tail_r]    <= 32'd0;
                tail_r             <= tail_r + IDX_W'(1);
            end
            if (cdb_hit_s) begin
                complete_r[cdb_idx_s] <= 1'b1;
                value_r[cdb_idx_s]    <= rob.cdb_value;
            end
            if (retire_fire_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + IDX_W'(1);
            end
            count_r <= count_r + TAG_W'(dispatch_fire_s) - TAG_W'(retire_fire_s);
        end
    end

    assign rob.dispatch_ready  = (count_r < TAG_W'(ROB_LEN));
    assign rob.dispatch_tag    = TAG_W'(tail_r) + TAG_W'(1);
    assign rob.rs1_query_ready = rs1_ready_s;
    assign rob.rs1_query_value = rs1_value_s;
    assign rob.rs2_query_ready = rs2_ready_s;
    assign rob.rs2_query_value = rs2_value_s;
    assign rob.retire_valid    = retire_fire_s;
    assign rob.retire_tag      = TAG_W'(head_r) + TAG_W'(1);
    assign rob.retire_dest_reg = dest_reg_r[head_r];
    assign rob.retire_value    = value_r[head_r];
    assign rob.count           = count_r;
    assign rob.empty           = (count_r == TAG_W'(0));
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
// Directed, table-driven bench for reorder_buffer (ROB_LEN = 8): one record
// per cycle of inputs and hand-computed outputs, followed by a hand-written
// asynchronous-reset sequence.
module tb_reorder_buffer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    reorder_buffer_if #(.ROB_LEN(8)) rob_bus ();

    reorder_buffer #(.ROB_LEN(8)) dut (
        .clock (clock),
        .reset (reset),
        .rob   (rob_bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        dv;
        logic [4:0]  dr;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cval;
        logic [3:0]  q1;
        logic [3:0]  q2;
        logic        sq;
        logic        rdy;
        logic [3:0]  dtag;
        logic [3:0]  cnt;
        logic        emp;
        logic        rv;
        logic [3:0]  rtag;
        logic [4:0]  rdest;
        logic [31:0] rval;
        logic        q1r;
        logic [31:0] q1v;
        logic        q2r;
        logic [31:0] q2v;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input int dv, dr, cv, ct, cval, q1, q2, sq,
                                input int rdy, dtag, cnt, emp, rv, rtag, rdest, rval,
                                input int q1r, q1v, q2r, q2v);
        vec_t v;
        v.dv = 1'(dv);     v.dr = 5'(dr);     v.cv = 1'(cv);     v.ct = 4'(ct);
        v.cval = 32'(cval); v.q1 = 4'(q1);    v.q2 = 4'(q2);     v.sq = 1'(sq);
        v.rdy = 1'(rdy);   v.dtag = 4'(dtag); v.cnt = 4'(cnt);   v.emp = 1'(emp);
        v.rv = 1'(rv);     v.rtag = 4'(rtag); v.rdest = 5'(rdest); v.rval = 32'(rval);
        v.q1r = 1'(q1r);   v.q1v = 32'(q1v);  v.q2r = 1'(q2r);   v.q2v = 32'(q2v);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rob_bus.dispatch_valid    = v.dv;
        rob_bus.dispatch_dest_reg = v.dr;
        rob_bus.cdb_valid         = v.cv;
        rob_bus.cdb_tag           = v.ct;
        rob_bus.cdb_value         = v.cval;
        rob_bus.rs1_query_tag     = v.q1;
        rob_bus.rs2_query_tag     = v.q2;
        rob_bus.squash            = v.sq;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d.dispatch_ready", i), 32'(rob_bus.dispatch_ready), 32'(v.rdy));
        chk($sformatf("v%0d.dispatch_tag", i), 32'(rob_bus.dispatch_tag), 32'(v.dtag));
        chk($sformatf("v%0d.count", i), 32'(rob_bus.count), 32'(v.cnt));
        chk($sformatf("v%0d.empty", i), 32'(rob_bus.empty), 32'(v.emp));
        chk($sformatf("v%0d.retire_valid", i), 32'(rob_bus.retire_valid), 32'(v.rv));
        if (v.rv) begin
            chk($sformatf("v%0d.retire_tag", i), 32'(rob_bus.retire_tag), 32'(v.rtag));
            chk($sformatf("v%0d.retire_dest_reg", i), 32'(rob_bus.retire_dest_reg), 32'(v.rdest));
            chk($sformatf("v%0d.retire_value", i), rob_bus.retire_value, v.rval);
        end
        chk($sformatf("v%0d.rs1_ready", i), 32'(rob_bus.rs1_query_ready), 32'(v.q1r));
        chk($sformatf("v%0d.rs1_value", i), rob_bus.rs1_query_value, v.q1v);
        chk($sformatf("v%0d.rs2_ready", i), 32'(rob_bus.rs2_query_ready), 32'(v.q2r));
        chk($sformatf("v%0d.rs2_value", i), rob_bus.rs2_query_value, v.q2v);
    endtask

    initial begin
        //               dv dr cv ct cval  q1 q2 sq | rdy dtag cnt emp rv rtag rdest rval  q1r q1v  q2r q2v
        // Fill 8 back-to-back, tags 1..8
        for (int k = 0; k < 8; k++) begin
            vecs[k] = mk(1, k+1, 0, 0, 0, 0, 0, 0,   1, k+1, k, (k == 0) ? 1 : 0, 0, 0, 0, 0,   0, 0, 0, 0);
        end
        // 9th dispatch while full: ignored, tail stays (dispatch_tag wraps to 1)
        vecs[8]  = mk(1, 9, 0, 0, 0,      0, 0, 0,   0, 1, 8, 0, 0, 0, 0, 0,       0, 0,     0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0,      0, 0, 0,   0, 1, 8, 0, 0, 0, 0, 0,       0, 0,     0, 0);
        // Out-of-order completion 3, 2, then 1; queries forward and persist
        vecs[10] = mk(0, 0, 1, 3, 30,     3, 2, 0,   0, 1, 8, 0, 0, 0, 0, 0,       1, 30,    0, 0);
        vecs[11] = mk(0, 0, 1, 2, 20,     3, 2, 0,   0, 1, 8, 0, 0, 0, 0, 0,       1, 30,    1, 20);
        vecs[12] = mk(0, 0, 1, 1, 10,     1, 0, 0,   0, 1, 8, 0, 0, 0, 0, 0,       1, 10,    0, 0);
        // Retire 1 while full with dispatch asserted: dispatch ignored
        vecs[13] = mk(1, 20, 0, 0, 0,     0, 0, 0,   0, 1, 8, 0, 1, 1, 1, 10,      0, 0,     0, 0);
        // Dispatch gets wrapped tag 1, retire 2 in same cycle
        vecs[14] = mk(1, 21, 0, 0, 0,     0, 0, 0,   1, 1, 7, 0, 1, 2, 2, 20,      0, 0,     0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0,      1, 3, 0,   1, 2, 7, 0, 1, 3, 3, 30,      0, 0,     1, 30);
        // Head (tag 4) incomplete; complete tags 6 then 4 then 5
        vecs[16] = mk(0, 0, 1, 6, 'h60,   6, 0, 0,   1, 2, 6, 0, 0, 0, 0, 0,       1, 'h60,  0, 0);
        vecs[17] = mk(0, 0, 1, 4, 'h55,   4, 0, 0,   1, 2, 6, 0, 0, 0, 0, 0,       1, 'h55,  0, 0);
        vecs[18] = mk(0, 0, 1, 5, 'h66,   4, 5, 0,   1, 2, 6, 0, 1, 4, 4, 'h55,    1, 'h55,  1, 'h66);
        // Squash with 5 entries (tags 5,6 complete) and a dispatch: nothing retires
        vecs[19] = mk(1, 7, 0, 0, 0,      0, 0, 1,   1, 2, 5, 0, 0, 0, 0, 0,       0, 0,     0, 0);
        vecs[20] = mk(0, 0, 1, 2, 'h77,   2, 6, 0,   1, 1, 0, 1, 0, 0, 0, 0,       0, 0,     0, 0);
        vecs[21] = mk(0, 0, 0, 0, 0,      2, 0, 0,   1, 1, 0, 1, 0, 0, 0, 0,       0, 0,     0, 0);
        // Minimum latency: dispatch tag 1, CDB next cycle, retire the cycle after
        vecs[22] = mk(1, 10, 0, 0, 0,     0, 0, 0,   1, 1, 0, 1, 0, 0, 0, 0,       0, 0,     0, 0);
        vecs[23] = mk(1, 11, 1, 1, 'hA1,  1, 0, 0,   1, 2, 1, 0, 0, 0, 0, 0,       1, 'hA1,  0, 0);
        vecs[24] = mk(1, 12, 0, 0, 0,     0, 0, 0,   1, 3, 2, 0, 1, 1, 10, 'hA1,   0, 0,     0, 0);
        vecs[25] = mk(1, 13, 0, 0, 0,     0, 0, 0,   1, 4, 2, 0, 0, 0, 0, 0,       0, 0,     0, 0);
        vecs[26] = mk(1, 14, 1, 2, 'hB2,  0, 0, 0,   1, 5, 3, 0, 0, 0, 0, 0,       0, 0,     0, 0);

        // Reset state
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset.count", 32'(rob_bus.count), 32'd0);
        chk("reset.empty", 32'(rob_bus.empty), 32'd1);
        chk("reset.dispatch_ready", 32'(rob_bus.dispatch_ready), 32'd1);
        chk("reset.dispatch_tag", 32'(rob_bus.dispatch_tag), 32'd1);
        chk("reset.retire_valid", 32'(rob_bus.retire_valid), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            @(negedge clock);
            check_vec(i, vecs[i]);
            @(posedge clock);
            #1;
        end

        // Async reset with 4 entries in flight (tags 2..5, head tag 2 complete)
        drive(mk(0, 0, 0, 0, 0, 2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        #1;
        chk("pre_reset.count", 32'(rob_bus.count), 32'd4);
        chk("pre_reset.retire_valid", 32'(rob_bus.retire_valid), 32'd1);
        chk("pre_reset.retire_tag", 32'(rob_bus.retire_tag), 32'd2);
        chk("pre_reset.retire_value", rob_bus.retire_value, 32'hB2);
        chk("pre_reset.rs1_value", rob_bus.rs1_query_value, 32'hB2);
        chk("pre_reset.dispatch_tag", 32'(rob_bus.dispatch_tag), 32'd6);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset.count", 32'(rob_bus.count), 32'd0);
        chk("async_reset.empty", 32'(rob_bus.empty), 32'd1);
        chk("async_reset.dispatch_ready", 32'(rob_bus.dispatch_ready), 32'd1);
        chk("async_reset.dispatch_tag", 32'(rob_bus.dispatch_tag), 32'd1);
        chk("async_reset.retire_valid", 32'(rob_bus.retire_valid), 32'd0);
        chk("async_reset.rs1_ready", 32'(rob_bus.rs1_query_ready), 32'd0);
        chk("async_reset.rs1_value", rob_bus.rs1_query_value, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_reset.count", 32'(rob_bus.count), 32'd0);
        chk("post_reset.retire_valid", 32'(rob_bus.retire_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
